cipher_core_arbiter: RTL

CIPHER_CORE_ARBITER -- requirements
Module: cipher_core_arbiter

---
 rtl/cipher_core_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cipher_core_arbiter.sv
// Two-requester round-robin front end for one shared cipher core.
// Owns the core for one block at a time and aborts a stalled core after TIMEOUT cycles.
module cipher_core_arbiter #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [63:0] msg0,
   input  logic [63:0] msg1,
   input  logic [63:0] key0,
   input  logic [63:0] key1,
   input  logic        ack0,
   input  logic        ack1,
   output logic        valid0,
   output logic        valid1,
   output logic [63:0] result,
   output logic        resp_err,
   output logic [1:0]  grant,
   output logic [63:0] core_message,
   output logic [63:0] core_key,
   output logic        core_enable,
   input  logic        core_done,
   input  logic [63:0] core_result,
   output logic        core_ack
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DELIVER
   } state_t;

   localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [1:0]  r_grant;
   logic        r_last;
   logic [63:0] r_msg;
   logic [63:0] r_key;
   logic [63:0] r_result;
   logic        r_err;
   logic [7:0]  r_cnt;

   logic w_any;
   logic w_pick1;
   logic w_to;
   logic w_ack_own;

   assign w_any     = req0 | req1;
   // r_last=1 means requester 1 was served last, so requester 0 wins a tie
   assign w_pick1   = req1 & (~req0 | ~r_last);
   assign w_to      = (r_cnt == LP_TO_LAST);
   assign w_ack_own = (r_grant[0] & ack0) | (r_grant[1] & ack1);

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (w_any) w_next = S_ISSUE;
         S_ISSUE:   w_next = S_WAIT;
         S_WAIT:    if (core_done || w_to) w_next = S_DELIVER;
         S_DELIVER: if (w_ack_own) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_grant  <= 2'b00;
         r_last   <= 1'b1;
         r_msg    <= '0;
         r_key    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick1 ? 2'b10 : 2'b01;
                  r_msg   <= w_pick1 ? msg1 : msg0;
                  r_key   <= w_pick1 ? key1 : key0;
               end
            end
            S_ISSUE: r_cnt <= '0;
            S_WAIT: begin
               if (core_done) begin
                  r_result <= core_result;
                  r_err    <= 1'b0;
               end else if (w_to) begin
                  r_result <= '0;
                  r_err    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_DELIVER: begin
               if (w_ack_own) begin
                  r_last  <= r_grant[1];
                  r_grant <= 2'b00;
               end
            end
            default: ;
         endcase
      end
   end

   assign grant        = r_grant;
   assign core_message = r_msg;
   assign core_key     = r_key;
   assign result       = r_result;
   assign resp_err     = r_err;
   assign core_enable  = (r_state == S_ISSUE);
   assign core_ack     = (r_state == S_WAIT) & core_done;
   assign valid0       = (r_state == S_DELIVER) & r_grant[0];
   assign valid1       = (r_state == S_DELIVER) & r_grant[1];

endmodule
